// File: rtl/flt2int_pkg.sv
// flt2int_pkg: shared types and constants for the half-precision to
// sign-magnitude integer converter (flt2int_seq).
//   f2i_state_t : converter FSM states
//   f2i_class_t : operand class decided at capture time
//   FLT_BIAS, MAX_MAG, MANT_W, CNT_W : format constants
package flt2int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } f2i_state_t;

  typedef enum logic [1:0] {
    CLS_ZERO  = 2'd0,
    CLS_SHIFT = 2'd1,
    CLS_SAT   = 2'd2
  } f2i_class_t;

  localparam int          FLT_BIAS = 15;
  localparam logic [14:0] MAX_MAG  = 15'h7FFF;
  localparam int          MANT_W   = 11;
  // Longest shift is 11 (e = -1 in the rounding build).
  localparam int          CNT_W    = 4;

endpackage

// File: rtl/flt2int_seq_if.sv
// flt2int_seq_if: request/result bundle between the fltflt core and the
// converter.
//   start   : request a conversion (core -> converter)
//   flt_in  : half-precision operand (core -> converter)
//   busy    : converter not idle
//   done    : one-cycle result-valid pulse
//   int_out : {sign, magnitude[14:0]}
//   ovf     : saturation flag for int_out
// Modports: master = core side, slave = converter side.
interface flt2int_seq_if;
  logic        start;
  logic [15:0] flt_in;
  logic        busy;
  logic        done;
  logic [15:0] int_out;
  logic        ovf;

  modport master (output start, flt_in, input busy, done, int_out, ovf);
  modport slave  (input start, flt_in, output busy, done, int_out, ovf);
endinterface

// File: rtl/flt_unpack.sv
// flt_unpack: combinational split of a half-precision operand into sign,
// mantissa (hidden bit restored), shift count, shift direction and class.
//   flt_i  : operand
//   sign_o : sign bit
//   mant_o : {hidden, fraction}, 11 bits
//   cnt_o  : number of single-bit shifts to perform
//   left_o : 1 = left shift, 0 = right shift
//   cls_o  : CLS_SAT (e > 14), CLS_SHIFT, or CLS_ZERO (magnitude is 0)
// Build option: FLT2INT_ROUND_EN adds the e = -1 right-shift path (n = 11)
// so that the guard bit can round 0.5 <= |x| < 1 up to 1.
module flt_unpack
  import flt2int_pkg::*;
(
  input  logic [15:0]       flt_i,
  output logic              sign_o,
  output logic [MANT_W-1:0] mant_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              left_o,
  output f2i_class_t        cls_o
);

  logic signed [5:0] exp_s;

  assign sign_o = flt_i[15];
  assign mant_o = {|flt_i[14:10], flt_i[9:0]};
  assign exp_s  = 6'({1'b0, flt_i[14:10]}) - 6'(FLT_BIAS);

  always_comb begin
    cls_o  = CLS_ZERO;
    cnt_o  = '0;
    left_o = 1'b0;
    if (exp_s > 6'sd14) begin
      cls_o = CLS_SAT;
    end else if (exp_s >= 6'sd11) begin
      cls_o  = CLS_SHIFT;
      left_o = 1'b1;
      cnt_o  = 4'(exp_s - 6'sd10);
    end else if (exp_s >= 6'sd0) begin
      cls_o = CLS_SHIFT;
      cnt_o = 4'(6'sd10 - exp_s);
    end
`ifdef FLT2INT_ROUND_EN
    else if (exp_s == -6'sd1) begin
      cls_o = CLS_SHIFT;
      cnt_o = 4'd11;
    end
`endif
  end

endmodule

// File: rtl/flt2int_seq.sv
// flt2int_seq: multi-cycle IEEE-754 half -> 16-bit sign-magnitude integer
// converter, one shift bit per clock.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : flt2int_seq_if.slave (start, flt_in, busy, done, int_out, ovf)
// Build option: FLT2INT_ROUND_EN -- round half away from zero using the last
// bit shifted out on right shifts; otherwise truncate toward zero.
//
// state | meaning
// IDLE  | waiting for start; operand captured and classified on accept
// CALC  | shifting one bit per cycle until count reaches 0, then latch result
// DONE  | done pulse, result valid; back to IDLE next cycle
module flt2int_seq
  import flt2int_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  flt2int_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      work_q, work_d;
  logic             left_q, left_d;
  logic             sign_q, sign_d;
  logic             sat_q, sat_d;
  logic [15:0]      int_q, int_d;
  logic             ovf_q, ovf_d;
`ifdef FLT2INT_ROUND_EN
  logic             guard_q, guard_d;
`endif

  logic              u_sign;
  logic [MANT_W-1:0] u_mant;
  logic [CNT_W-1:0]  u_cnt;
  logic              u_left;
  f2i_class_t        u_cls;
  logic [14:0]       mag_fin;

  flt_unpack u_unpack (
    .flt_i  (bus.flt_in),
    .sign_o (u_sign),
    .mant_o (u_mant),
    .cnt_o  (u_cnt),
    .left_o (u_left),
    .cls_o  (u_cls)
  );

  // Left shifts top out at 32752, so work_q[15] never sets; it is folded into
  // saturation only as a guard against a wrong count.
`ifdef FLT2INT_ROUND_EN
  assign mag_fin = (sat_q | work_q[15]) ? MAX_MAG : work_q[14:0] + {14'd0, guard_q};
`else
  assign mag_fin = (sat_q | work_q[15]) ? MAX_MAG : work_q[14:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    left_d  = left_q;
    sign_d  = sign_q;
    sat_d   = sat_q;
    int_d   = int_q;
    ovf_d   = ovf_q;
`ifdef FLT2INT_ROUND_EN
    guard_d = guard_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sign_d  = u_sign;
          left_d  = u_left;
          cnt_d   = u_cnt;
          sat_d   = (u_cls == CLS_SAT);
          work_d  = (u_cls == CLS_SHIFT) ? 16'(u_mant) : 16'h0000;
`ifdef FLT2INT_ROUND_EN
          guard_d = 1'b0;
`endif
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (left_q) begin
            work_d = {work_q[14:0], 1'b0};
          end else begin
            work_d  = {1'b0, work_q[15:1]};
`ifdef FLT2INT_ROUND_EN
            guard_d = work_q[0];
`endif
          end
        end else begin
          // No negative zero: sign only survives a nonzero magnitude.
          int_d   = {sign_q & (|mag_fin), mag_fin};
          ovf_d   = sat_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      left_q  <= 1'b0;
      sign_q  <= 1'b0;
      sat_q   <= 1'b0;
      int_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef FLT2INT_ROUND_EN
      guard_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      left_q  <= left_d;
      sign_q  <= sign_d;
      sat_q   <= sat_d;
      int_q   <= int_d;
      ovf_q   <= ovf_d;
`ifdef FLT2INT_ROUND_EN
      guard_q <= guard_d;
`endif
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.int_out = int_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_flt2int_seq.sv
// tb_flt2int_seq: directed bench for flt2int_seq. Expected results come from a
// real-arithmetic model of the half-precision value; a single negedge process
// checks every done pulse (value, ovf, latency) and output stability/busy in
// all other cycles. Honours FLT2INT_ROUND_EN when compiled with it.
module tb_flt2int_seq;

  typedef struct {
    logic [15:0] v;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  flt2int_seq_if bus ();

  flt2int_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  // Value-level model: x = mant * 2^(e-10); integer part (or rounded) of |x|.
  function automatic void model(input logic [15:0] f, output logic [15:0] v,
                                output logic o, output int lat);
    int  e;
    int  m;
    int  mag;
    int  n;
    real val;
    real r;
    e   = int'(f[14:10]) - 15;
    m   = int'({|f[14:10], f[9:0]});
    val = real'(m) * pow2(e - 10);
`ifdef FLT2INT_ROUND_EN
    r = $floor(val + 0.5);
`else
    r = $floor(val);
`endif
    if (val >= 32768.0) begin
      v   = {f[15], 15'h7FFF};
      o   = 1'b1;
      lat = 1;
    end else begin
      mag = int'(r);
      v   = {f[15] && (mag != 0), 15'(mag)};
      o   = 1'b0;
      if (e >= 0 && e <= 10) n = 10 - e;
      else if (e >= 11) n = e - 10;
`ifdef FLT2INT_ROUND_EN
      else if (e == -1) n = 11;
`endif
      else n = 0;
      lat = n + 1;
    end
  endfunction

  // Compare process.
  initial begin : cmp
    exp_t        it;
    logic [15:0] held_v;
    logic        held_ovf;
    held_v   = 16'h0000;
    held_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        q.delete();
        held_v   = 16'h0000;
        held_ovf = 1'b0;
      end else if (bus.done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 16'(bus.done), 16'h0);
        end else begin
          it = q.pop_front();
          chk("int_out", bus.int_out, it.v);
          chk("ovf", 16'(bus.ovf), 16'(it.ovf));
          chk("latency", 16'(cyc), 16'(it.due));
          held_v   = it.v;
          held_ovf = it.ovf;
        end
      end else begin
        chk("hold_int_out", bus.int_out, held_v);
        chk("hold_ovf", 16'(bus.ovf), 16'(held_ovf));
        chk("busy", 16'(bus.busy), 16'(q.size() != 0));
      end
    end
  end

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 40; i++) begin
      if (q.size() == 0 && !bus.busy) break;
      @(negedge clk);
      #1;
    end
    n_vec++;
    if (q.size() != 0 || bus.busy) begin
      n_err++;
      $display("FAIL %s timeout: busy=%b pending=%0d, expected idle", nm, bus.busy, q.size());
    end
  endtask

  // poke > 0: pulse start with a different operand that many cycles into CALC.
  task automatic convert(input logic [15:0] f, input int poke);
    logic [15:0] v;
    logic        o;
    int          lat;
    model(f, v, o, lat);
    wait_idle("pre_start");
    bus.flt_in = f;
    bus.start  = 1'b1;
    q.push_back('{v, o, cyc + 1 + lat});
    @(negedge clk);
    #1;
    bus.start = 1'b0;
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      #1;
      bus.flt_in = 16'h7C00;
      bus.start  = 1'b1;
      @(negedge clk);
      #1;
      bus.start = 1'b0;
    end
    wait_idle("convert");
  endtask

  task automatic pin(input logic [15:0] f, input logic [15:0] ev, input logic eo, input int el);
    logic [15:0] v;
    logic        o;
    int          lat;
    model(f, v, o, lat);
    chk("model_val", v, ev);
    chk("model_ovf", 16'(o), 16'(eo));
    chk("model_lat", 16'(lat), 16'(el));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] vecs [16];
    vecs = '{16'hC204, 16'hEC10, 16'h7C00, 16'hFC00, 16'h3E00, 16'h3800,
             16'h8000, 16'h0000, 16'h7BFF, 16'h77FF, 16'h0001, 16'h4900,
             16'hB800, 16'h3BFF, 16'h6400, 16'hC3FF};
    bus.start  = 1'b0;
    bus.flt_in = 16'h0000;

    // Hand-computed pins of the model.
    pin(16'hC204, 16'h8003, 1'b0, 10);
    pin(16'hEC10, 16'h9040, 1'b0, 3);
    pin(16'h7C00, 16'h7FFF, 1'b1, 1);
    pin(16'hFC00, 16'hFFFF, 1'b1, 1);
    pin(16'h8000, 16'h0000, 1'b0, 1);
    pin(16'h3C00, 16'h0001, 1'b0, 11);
`ifdef FLT2INT_ROUND_EN
    pin(16'h3E00, 16'h0002, 1'b0, 11);
    pin(16'h3800, 16'h0001, 1'b0, 12);
`else
    pin(16'h3E00, 16'h0001, 1'b0, 11);
    pin(16'h3800, 16'h0000, 1'b0, 1);
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_done", 16'(bus.done), 16'h0);
    chk("rst_int_out", bus.int_out, 16'h0000);
    chk("rst_ovf", 16'(bus.ovf), 16'h0);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;

    foreach (vecs[i]) convert(vecs[i], 0);

    // Start during CALC is ignored.
    convert(16'h3C00, 3);

    // Reset mid-conversion.
    wait_idle("pre_reset");
    bus.flt_in = 16'h3C00;
    bus.start  = 1'b1;
    q.push_back('{16'h0001, 1'b0, cyc + 12});
    @(negedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 16'(bus.busy), 16'h0);
    chk("abort_done", 16'(bus.done), 16'h0);
    chk("abort_int_out", bus.int_out, 16'h0000);
    chk("abort_ovf", 16'(bus.ovf), 16'h0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    convert(16'h3C00, 0);
    convert(16'hEC10, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
